// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot memory sequencer.
// Optional checksum checking is compiled in with BOOT_CHECKSUM_EN.
package boot_seq_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    RELEASE,
    RUN,
    ERR
  } boot_state_t;

  localparam int   WORD_BYTES    = 4;
  localparam logic BUS_IDLE_WE_L = 1'b1;

  // Word index to byte address, truncated to the 32-bit bus.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/boot_bus_mux.sv
// Combinational data-RAM bus selection: the core owns the bus only in RUN,
// otherwise the sequencer's registered bus drives it.
module boot_bus_mux (
  input  logic        run,
  input  logic [31:0] seq_address,
  input  logic [31:0] seq_data_out,
  input  logic        seq_WE_L,
  input  logic        seq_AS_L,
  input  logic        seq_RAM_Select,
  input  logic [31:0] core_address,
  input  logic [31:0] core_data_out,
  input  logic        core_WE_L,
  input  logic        core_AS_L,
  input  logic        core_RAM_Select,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_WE_L,
  output logic        mem_AS_L,
  output logic        mem_RAM_Select
);

  assign mem_address    = run ? core_address    : seq_address;
  assign mem_data_out   = run ? core_data_out   : seq_data_out;
  assign mem_WE_L       = run ? core_WE_L       : seq_WE_L;
  assign mem_AS_L       = run ? core_AS_L       : seq_AS_L;
  assign mem_RAM_Select = run ? core_RAM_Select : seq_RAM_Select;

endmodule

// File: rtl/boot_mem_sequencer.sv
// Boot sequencer: clears data RAM, streams the image into instruction memory,
// then releases the core. Define BOOT_CHECKSUM_EN for image checksum checking.
module boot_mem_sequencer
  import boot_seq_pkg::*;
#(
  parameter int DATA_WORDS     = 1024,
  parameter int INSTR_WORDS    = 256,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_L,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        core_reset_L,
  input  logic [31:0] core_address,
  input  logic [31:0] core_data_out,
  input  logic        core_WE_L,
  input  logic        core_AS_L,
  input  logic        core_RAM_Select,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_WE_L,
  output logic        mem_AS_L,
  output logic        mem_RAM_Select,
  output logic        instr_we,
  output logic [31:0] instr_address,
  output logic [31:0] instr_wdata,
  output logic        busy,
  output logic        error
);

  boot_state_t state, next_state;
  logic [31:0] cnt;
  logic [31:0] seq_address, seq_data_out;
  logic        seq_WE_L, seq_AS_L, seq_RAM_Select;
  logic        accept, run;
  logic        last_clear, last_word, last_release;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_word;
`endif

  assign accept       = load_valid && load_ready;
  assign last_clear   = (cnt == 32'(DATA_WORDS - 1));
  assign last_word    = (cnt == 32'(INSTR_WORDS - 1));
  assign last_release = (cnt == 32'(RELEASE_CYCLES - 1));
`ifdef BOOT_CHECKSUM_EN
  assign sum_word     = (cnt == 32'(INSTR_WORDS));
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) state <= CLEAR;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (last_clear) next_state = LOAD;
`ifdef BOOT_CHECKSUM_EN
      LOAD:    if (accept && sum_word) next_state = (load_data == sum) ? RELEASE : ERR;
`else
      LOAD:    if (accept && last_word) next_state = RELEASE;
`endif
      RELEASE: if (last_release) next_state = RUN;
      RUN:     if (start) next_state = CLEAR;
      ERR:     next_state = ERR;
      default: next_state = CLEAR;
    endcase
  end

  assign run          = (state == RUN);
  assign load_ready   = (state == LOAD);
  assign core_reset_L = run;
  assign busy         = !run;
`ifdef BOOT_CHECKSUM_EN
  assign error        = (state == ERR);
`else
  assign error        = 1'b0;
`endif

  // Sequencer bus and instruction port are registered; they idle unless a write is issued.
  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt            <= '0;
      seq_address    <= '0;
      seq_data_out   <= '0;
      seq_WE_L       <= BUS_IDLE_WE_L;
      seq_AS_L       <= 1'b1;
      seq_RAM_Select <= 1'b0;
      instr_we       <= 1'b0;
      instr_address  <= '0;
      instr_wdata    <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum            <= '0;
`endif
    end else begin
      seq_address    <= '0;
      seq_data_out   <= '0;
      seq_WE_L       <= BUS_IDLE_WE_L;
      seq_AS_L       <= 1'b1;
      seq_RAM_Select <= 1'b0;
      instr_we       <= 1'b0;
      case (state)
        CLEAR: begin
          seq_address    <= word_addr(cnt);
          seq_WE_L       <= 1'b0;
          seq_AS_L       <= 1'b0;
          seq_RAM_Select <= 1'b1;
          cnt            <= last_clear ? '0 : cnt + 32'd1;
`ifdef BOOT_CHECKSUM_EN
          sum            <= '0;
`endif
        end
        LOAD: begin
          if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            // The word after the image is the checksum and is never written.
            if (sum_word) begin
              cnt <= '0;
            end else begin
              instr_we      <= 1'b1;
              instr_address <= word_addr(cnt);
              instr_wdata   <= load_data;
              sum           <= sum + load_data;
              cnt           <= cnt + 32'd1;
            end
`else
            instr_we      <= 1'b1;
            instr_address <= word_addr(cnt);
            instr_wdata   <= load_data;
            cnt           <= last_word ? '0 : cnt + 32'd1;
`endif
          end
        end
        RELEASE: cnt <= last_release ? '0 : cnt + 32'd1;
        RUN:     cnt <= '0;
        default: cnt <= cnt;
      endcase
    end
  end

  boot_bus_mux u_bus_mux (
    .run            (run),
    .seq_address    (seq_address),
    .seq_data_out   (seq_data_out),
    .seq_WE_L       (seq_WE_L),
    .seq_AS_L       (seq_AS_L),
    .seq_RAM_Select (seq_RAM_Select),
    .core_address   (core_address),
    .core_data_out  (core_data_out),
    .core_WE_L      (core_WE_L),
    .core_AS_L      (core_AS_L),
    .core_RAM_Select(core_RAM_Select),
    .mem_address    (mem_address),
    .mem_data_out   (mem_data_out),
    .mem_WE_L       (mem_WE_L),
    .mem_AS_L       (mem_AS_L),
    .mem_RAM_Select (mem_RAM_Select)
  );

endmodule

// File: tb/tb_boot_mem_sequencer.sv
// Self-checking bench for boot_mem_sequencer (default parameters); covers the
// BOOT_CHECKSUM_EN build as well when that macro is defined.
module tb_boot_mem_sequencer;

  localparam int DATA_WORDS     = 1024;
  localparam int INSTR_WORDS    = 256;
  localparam int RELEASE_CYCLES = 4;
`ifdef BOOT_CHECKSUM_EN
  localparam int LATENCY = DATA_WORDS + INSTR_WORDS + RELEASE_CYCLES + 1;
`else
  localparam int LATENCY = DATA_WORDS + INSTR_WORDS + RELEASE_CYCLES;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        RESET_L, start, load_valid, load_ready, core_reset_L;
  logic [31:0] load_data;
  logic [31:0] core_address, core_data_out;
  logic        core_WE_L, core_AS_L, core_RAM_Select;
  logic [31:0] mem_address, mem_data_out;
  logic        mem_WE_L, mem_AS_L, mem_RAM_Select;
  logic        instr_we, busy, error;
  logic [31:0] instr_address, instr_wdata;

  always #10 CLOCK_50 = ~CLOCK_50;

  boot_mem_sequencer #(
    .DATA_WORDS(DATA_WORDS), .INSTR_WORDS(INSTR_WORDS), .RELEASE_CYCLES(RELEASE_CYCLES)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_L(RESET_L), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .core_reset_L(core_reset_L),
    .core_address(core_address), .core_data_out(core_data_out),
    .core_WE_L(core_WE_L), .core_AS_L(core_AS_L), .core_RAM_Select(core_RAM_Select),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_WE_L(mem_WE_L), .mem_AS_L(mem_AS_L), .mem_RAM_Select(mem_RAM_Select),
    .instr_we(instr_we), .instr_address(instr_address), .instr_wdata(instr_wdata),
    .busy(busy), .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } instr_exp_t;

  typedef struct {
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic        c_we_l;
    logic        c_as_l;
    logic        c_sel;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic        e_we_l;
    logic        e_as_l;
    logic        e_sel;
  } run_vec_t;

  instr_exp_t  exp_q[$];
  run_vec_t    vecs[4];
  int          compared = 0;
  int          mismatched = 0;
  int          clear_exp, accept_cnt, instr_pulses, cyc_idx;
  logic [31:0] sum_model;
  bit          toggle_mode, bad_sum;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] image_word(input int idx);
    if (toggle_mode) return 32'h0000_0013;
    return 32'h0000_0013 + (32'(idx) << 8);
  endfunction

  task automatic restartModel();
    clear_exp    = 0;
    accept_cnt   = 0;
    instr_pulses = 0;
    cyc_idx      = 0;
    sum_model    = '0;
    exp_q.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_core_reset_L"}, 32'(core_reset_L), 32'd0);
    checkOutput({tag, "_load_ready"}, 32'(load_ready), 32'd0);
    checkOutput({tag, "_instr_we"}, 32'(instr_we), 32'd0);
    checkOutput({tag, "_mem_WE_L"}, 32'(mem_WE_L), 32'd1);
    checkOutput({tag, "_mem_AS_L"}, 32'(mem_AS_L), 32'd1);
    checkOutput({tag, "_mem_RAM_Select"}, 32'(mem_RAM_Select), 32'd0);
    checkOutput({tag, "_mem_address"}, mem_address, 32'd0);
    checkOutput({tag, "_mem_data_out"}, mem_data_out, 32'd0);
    checkOutput({tag, "_instr_address"}, instr_address, 32'd0);
    checkOutput({tag, "_instr_wdata"}, instr_wdata, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic waitForRun(input int budget, output int cycles);
    cycles = 0;
    while (!core_reset_L && cycles < budget) begin
      @(posedge CLOCK_50);
      #1;
      cycles++;
    end
    if (!core_reset_L) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL run_timeout: core_reset_L still 0 after %0d cycles, expected 1", cycles);
    end
  endtask

  task automatic applyStimulus(input run_vec_t v, input int idx);
    @(negedge CLOCK_50);
    #2;
    core_address    = v.c_addr;
    core_data_out   = v.c_data;
    core_WE_L       = v.c_we_l;
    core_AS_L       = v.c_as_l;
    core_RAM_Select = v.c_sel;
    #1;
    checkOutput($sformatf("run_mem_address_%0d", idx), mem_address, v.e_addr);
    checkOutput($sformatf("run_mem_data_out_%0d", idx), mem_data_out, v.e_data);
    checkOutput($sformatf("run_mem_WE_L_%0d", idx), 32'(mem_WE_L), 32'(v.e_we_l));
    checkOutput($sformatf("run_mem_AS_L_%0d", idx), 32'(mem_AS_L), 32'(v.e_as_l));
    checkOutput($sformatf("run_mem_RAM_Select_%0d", idx), 32'(mem_RAM_Select), 32'(v.e_sel));
  endtask

  // Monitor first (clear writes, instruction pulses), then drive the next load word.
  always @(negedge CLOCK_50) begin : mon_drv
    instr_exp_t e;
    if (RESET_L && busy && !mem_AS_L) begin
      checkOutput("clear_addr", mem_address, 32'(clear_exp) << 2);
      checkOutput("clear_data", mem_data_out, 32'd0);
      checkOutput("clear_we_l", 32'(mem_WE_L), 32'd0);
      checkOutput("clear_sel", 32'(mem_RAM_Select), 32'd1);
      clear_exp++;
    end
    if (instr_we) begin
      instr_pulses++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_instr_we: addr 0x%08h with no accepted word pending", instr_address);
      end else begin
        e = exp_q.pop_front();
        checkOutput("instr_addr", instr_address, e.addr);
        checkOutput("instr_data", instr_wdata, e.data);
      end
    end
    load_valid = toggle_mode ? ((cyc_idx % 4 == 0) || (cyc_idx % 4 == 3)) : 1'b1;
    cyc_idx++;
    if (accept_cnt < INSTR_WORDS) load_data = image_word(accept_cnt);
    else                          load_data = sum_model + (bad_sum ? 32'd1 : 32'd0);
    if (RESET_L && load_valid && load_ready) begin
      if (accept_cnt < INSTR_WORDS) begin
        exp_q.push_back('{32'(accept_cnt) << 2, load_data});
        sum_model += load_data;
      end
      accept_cnt++;
    end
  end

  initial begin
    int cycles;
    vecs[0] = '{32'h0000_0218, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0000_0218, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0FFC, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0004, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0};

    RESET_L = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    core_address = 32'h1234_5678;
    core_data_out = 32'hCAFE_F00D;
    core_WE_L = 1'b0;
    core_AS_L = 1'b0;
    core_RAM_Select = 1'b1;
    toggle_mode = 1'b0;
    bad_sum = 1'b0;
    restartModel();

    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetOutputs("por");

    // Full boot with continuous valid; latency counted from RESET_L rising.
    @(negedge CLOCK_50);
    #2;
    RESET_L = 1'b1;
    waitForRun(5000, cycles);
    checkOutput("boot_latency", 32'(cycles), 32'(LATENCY));
    checkOutput("boot_clear_count", 32'(clear_exp), 32'(DATA_WORDS));
    checkOutput("boot_instr_pulses", 32'(instr_pulses), 32'(INSTR_WORDS));
    checkOutput("boot_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("run_busy", 32'(busy), 32'd0);
    checkOutput("run_error", 32'(error), 32'd0);
    checkOutput("run_load_ready", 32'(load_ready), 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // Reboot via start with gapped valid; start held on afterwards must be ignored.
    @(negedge CLOCK_50);
    #2;
    toggle_mode = 1'b1;
    restartModel();
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    checkOutput("start_core_reset_L", 32'(core_reset_L), 32'd0);
    checkOutput("start_busy", 32'(busy), 32'd1);
    repeat (10) @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    waitForRun(20000, cycles);
    checkOutput("gap_clear_count", 32'(clear_exp), 32'(DATA_WORDS));
    checkOutput("gap_instr_pulses", 32'(instr_pulses), 32'(INSTR_WORDS));
    checkOutput("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reboot, then abort with RESET_L at clear word 500.
    @(negedge CLOCK_50);
    #2;
    toggle_mode = 1'b0;
    restartModel();
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    cycles = 0;
    while (clear_exp < 500 && cycles < 2000) begin
      @(negedge CLOCK_50);
      cycles++;
    end
    checkOutput("abort_reached_500", 32'(clear_exp), 32'd500);
    #2;
    RESET_L = 1'b0;
    #1;
    checkResetOutputs("abort");
    restartModel();
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    #2;
    RESET_L = 1'b1;
    waitForRun(5000, cycles);
    checkOutput("abort_latency", 32'(cycles), 32'(LATENCY));
    checkOutput("abort_clear_count", 32'(clear_exp), 32'(DATA_WORDS));
    checkOutput("abort_instr_pulses", 32'(instr_pulses), 32'(INSTR_WORDS));

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum word must park the sequencer in its error state.
    @(negedge CLOCK_50);
    #2;
    restartModel();
    bad_sum = 1'b1;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    cycles = 0;
    while (!error && cycles < 5000) begin
      @(posedge CLOCK_50);
      #1;
      cycles++;
    end
    repeat (10) @(posedge CLOCK_50);
    #1;
    checkOutput("err_error", 32'(error), 32'd1);
    checkOutput("err_core_reset_L", 32'(core_reset_L), 32'd0);
    checkOutput("err_busy", 32'(busy), 32'd1);
    checkOutput("err_load_ready", 32'(load_ready), 32'd0);
    checkOutput("err_instr_pulses", 32'(instr_pulses), 32'(INSTR_WORDS));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/boot_mem_sequencer.md
Name: boot_mem_sequencer

Overview:
Owns the shared memory bus between the RISC-V core and a boot loader path. After reset it holds the core in reset, zero-fills data RAM, then streams the program image into instruction memory over a valid/ready port. It then releases the core and hands the bus to it. A later `start` pulse reboots the system through the same sequence.

Parameters:
DATA_WORDS, 1024, number of 32-bit data-RAM words cleared; byte addresses 0..4*DATA_WORDS-4, stride 4.
INSTR_WORDS, 256, number of instruction words loaded; byte addresses 0..4*INSTR_WORDS-4.
RELEASE_CYCLES, 4, cycles the core stays held after load completes, before its reset is released.

Ports:
CLOCK_50  in  1  system clock; all state changes on its rising edge.
RESET_L  in  1  asynchronous, active-low reset.
start  in  1  single-cycle reboot request; sampled only in RUN.
load_valid  in  1  image word is valid this cycle.
load_data  in  32  image word, little-endian instruction.
load_ready  out  1  sequencer accepts a word this cycle.
core_reset_L  out  1  active-low reset to the core.
core_address  in  32  core bus address.
core_data_out  in  32  core write data.
core_WE_L  in  1  core write enable, active-low.
core_AS_L  in  1  core address strobe, active-low.
core_RAM_Select  in  1  core RAM select.
mem_address  out  32  muxed address to data RAM.
mem_data_out  out  32  muxed write data to data RAM.
mem_WE_L  out  1  muxed write enable, active-low.
mem_AS_L  out  1  muxed address strobe, active-low.
mem_RAM_Select  out  1  muxed RAM select.
instr_we  out  1  instruction-memory write strobe.
instr_address  out  32  instruction-memory byte address.
instr_wdata  out  32  instruction-memory write data.
busy  out  1  high in every state except RUN.
error  out  1  checksum mismatch; see Optional Feature.

Behaviour:
- States: CLEAR, LOAD, RELEASE, RUN, plus ERR when the optional feature is compiled in. A 32-bit counter `cnt` is shared across states.
- Reset (asynchronous, RESET_L=0):
  - state=CLEAR, cnt=0.
  - Outputs: core_reset_L=0, load_ready=0, instr_we=0, mem_WE_L=1, mem_AS_L=1, mem_RAM_Select=0, mem_address=0, mem_data_out=0, instr_address=0, instr_wdata=0, busy=1, error=0.
- Reset asserted mid-sequence aborts immediately. No partial write is completed after RESET_L falls.
- CLEAR:
  - Each cycle drives a registered write: mem_AS_L=0, mem_WE_L=0, mem_RAM_Select=1, mem_address=4*cnt, mem_data_out=0.
  - cnt increments by 1 per cycle. When cnt==DATA_WORDS-1 is written: cnt<=0, go to LOAD.
  - Exactly DATA_WORDS writes, one per cycle.
- LOAD:
  - load_ready=1 (combinational from state).
  - On load_valid&&load_ready: next cycle instr_we=1, instr_address=4*cnt, instr_wdata=load_data; cnt++.
  - instr_we is a one-cycle pulse per accepted word; it is 0 otherwise.
  - Gaps in load_valid are tolerated with no timeout.
  - After word INSTR_WORDS-1 is accepted: cnt<=0, go to RELEASE. load_ready drops in the same cycle the state changes.
- RELEASE: core_reset_L stays 0 for RELEASE_CYCLES cycles, then go to RUN.
- RUN:
  - core_reset_L=1, busy=0.
  - mem_* follow core_* combinationally, with zero added latency.
  - instr_we=0.
- In every state other than RUN, core_* inputs are ignored and mem_* are driven by the sequencer.
- start in RUN: next cycle core_reset_L=0, state=CLEAR, cnt=0. start outside RUN is ignored.
- Address arithmetic is cnt<<2, truncated to 32 bits. Counters never wrap past their terminal value.
- Total latency from RESET_L rising to core_reset_L=1, with load_valid held 1: DATA_WORDS+INSTR_WORDS+RELEASE_CYCLES cycles.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- When defined:
  - A 32-bit running sum (mod 2^32) of accepted image words is kept; it is cleared on entry to CLEAR.
  - LOAD accepts one extra word after INSTR_WORDS. This word is not written to instruction memory.
  - If the extra word equals the sum: go to RELEASE. Otherwise go to ERR.
  - ERR: error=1, core_reset_L=0, busy=1, load_ready=0. ERR is left only via RESET_L.
- When undefined: error is tied to 0, there is no extra word, and the ERR state does not exist.

Decomposition:
- Package boot_seq_pkg holds:
  - enum boot_state_t {CLEAR, LOAD, RELEASE, RUN, ERR}.
  - Constants WORD_BYTES=4 and BUS_IDLE_WE_L=1.
- Sub-module boot_bus_mux is natural: the purely combinational selection of sequencer versus core onto mem_*, keyed on state==RUN.

Test Plan:
- Reset, DATA_WORDS=1024, INSTR_WORDS=256, load_valid=1 continuous:
  - 1024 writes of 0 at addresses 0x000..0xFFC on consecutive cycles.
  - Then 256 instr_we pulses at 0x000..0x3FC.
  - core_reset_L rises exactly 1284 cycles after RESET_L rises.
- load_valid toggled 1,0,0,1 repeating, image words 0x00000013 (NOP):
  - instr_we count equals the number of accepted words.
  - No writes occur during gaps; addresses stay contiguous.
- In RUN, core drives address 0x218, WE_L=0, data 0xDEADBEEF:
  - mem_address=0x218 and mem_data_out=0xDEADBEEF in the same cycle.
- RESET_L pulsed low at clear word 500:
  - All outputs return to reset values immediately.
  - CLEAR restarts at address 0.
- start pulsed in RUN: core_reset_L=0 the next cycle, and a full clear+load is repeated.
- With BOOT_CHECKSUM_EN, 2 NOPs followed by checksum 0x00000026: RUN is reached. With checksum 0x00000027: error=1 and core stays held.
